// File: rtl/rover_bidir_pio.sv
// Bidirectional parallel I/O slave: per-pin direction, synchronised inputs,
// sticky edge capture with interrupt mask, and atomic set/clear of the outputs.
module rover_bidir_pio #(
  parameter int unsigned WIDTH       = 8,
  parameter logic [31:0] RESET_OUT   = 32'hFFFF_FFFF,
  parameter logic [31:0] RESET_DIR   = 32'h0000_0000,
  parameter int unsigned EDGE_TYPE   = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  inout  wire  [WIDTH-1:0]  bidir_port
);

  localparam int unsigned PRIME_MAX = SYNC_STAGES + 1;
  localparam int unsigned PW        = $clog2(PRIME_MAX + 1);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_DIR    = 3'd1;
  localparam logic [2:0] A_MASK   = 3'd2;
  localparam logic [2:0] A_EDGE   = 3'd3;
  localparam logic [2:0] A_OUTSET = 3'd4;
  localparam logic [2:0] A_OUTCLR = 3'd5;

  logic [WIDTH-1:0]                   data_out_q, data_out_d;
  logic [WIDTH-1:0]                   data_dir_q, data_dir_d;
  logic [WIDTH-1:0]                   irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0]                   edge_cap_q, edge_cap_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0]  sync_q;
  logic [WIDTH-1:0]                   prev_q;
  logic [PW-1:0]                      prime_q, prime_d;
  logic [31:0]                        readdata_q, readdata_d;

  logic [WIDTH-1:0] pin_in;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] rd_mux;
  logic             wr_en;
  logic             edge_en;
  logic             unused_wd;

  // Each pin is released to Z unless its direction bit asks us to drive it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign bidir_port[i] = data_dir_q[i] ? data_out_q[i] : 1'bz;
  end

  assign pin_in    = bidir_port;
  assign sync_in   = sync_q[SYNC_STAGES-1];
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign wr_en     = chipselect & ~write_n;
  assign edge_en   = (prime_q == PW'(PRIME_MAX));

  always_comb begin
    ev = sync_in ^ prev_q;
    if (EDGE_TYPE == 0) begin
      ev = sync_in & ~prev_q;
    end else if (EDGE_TYPE == 1) begin
      ev = ~sync_in & prev_q;
    end
  end

  always_comb begin
    data_out_d = data_out_q;
    data_dir_d = data_dir_q;
    irq_mask_d = irq_mask_q;
    clr        = '0;
    if (wr_en) begin
      case (address)
        A_DATA:   data_out_d = wd;
        A_DIR:    data_dir_d = wd;
        A_MASK:   irq_mask_d = wd;
        A_EDGE:   clr        = wd;
        A_OUTSET: data_out_d = data_out_q | wd;
        A_OUTCLR: data_out_d = data_out_q & ~wd;
        default:  ;
      endcase
    end
    // A new event in the same cycle as a clear-write leaves the bit set.
    edge_cap_d = (edge_cap_q & ~clr) | (edge_en ? ev : '0);
    prime_d    = edge_en ? prime_q : prime_q + 1'b1;
  end

  always_comb begin
    case (address)
      A_DATA:  rd_mux = sync_in;
      A_DIR:   rd_mux = data_dir_q;
      A_MASK:  rd_mux = irq_mask_q;
      A_EDGE:  rd_mux = edge_cap_q;
      default: rd_mux = '0;
    endcase
    readdata_d = 32'(rd_mux);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= RESET_OUT[WIDTH-1:0];
      data_dir_q <= RESET_DIR[WIDTH-1:0];
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      sync_q     <= '0;
      prev_q     <= '0;
      prime_q    <= '0;
      readdata_q <= '0;
    end else begin
      data_out_q <= data_out_d;
      data_dir_q <= data_dir_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], pin_in};
      prev_q     <= sync_in;
      prime_q    <= prime_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_cap_q & irq_mask_q);

endmodule
